sclk_gen: RTL
=============

# sclk_gen

Programmable, burst-capable serial clock generator; successor to the fixed-ratio enable-gated divider. Produces a divided output clock with a runtime half-period and idle polarity, emits a requested number of cycles (or runs until stopped), and provides leading/trailing edge strobes in the `clk_i` domain. Intended as the shared SCLK/SCL source for the SPI and I2C masters, so shift logic keys off strobes instead of sampling `clk_o`.

## Interface
- `DIV_WIDTH`, 8: width of `half_period_i` and of the phase counter.
- `COUNT_WIDTH`, 8: width of `count_i` and of the remaining-cycle counter.
- `IDLE_HIGH`, 1: 1 = `clk_o` idles high, 0 = idles low.

Ports:
- `clk_i` in 1: system clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `half_period_i` in DIV_WIDTH: half-period H in `clk_i` cycles; 0 is treated as 1; latched at start.
- `count_i` in COUNT_WIDTH: number of output cycles N; 0 = free-running until `stop_i`; latched at start.
- `start_i` in 1: begin burst; honoured only when `busy_o` is low.
- `stop_i` in 1: request end of a running burst; sticky until burst ends.
- `clk_o` out 1: divided clock, registered.
- `busy_o` out 1: high from the cycle after accepted start until burst completes.
- `lead_o` out 1: one-cycle strobe in the cycle `clk_o` leaves idle level.
- `trail_o` out 1: one-cycle strobe in the cycle `clk_o` returns to idle level.
- `done_o` out 1: one-cycle strobe when the burst ends.

## Operation
- States (one-hot): IDLE, ACTIVE (`clk_o` at non-idle level), INACTIVE (`clk_o` at idle level within burst).
- IDLE: `clk_o` = idle level, `busy_o` = 0. `start_i` -> latch H (max(H,1)) and N, clear stop flag, go ACTIVE.
- ACTIVE: hold H cycles, then go INACTIVE; decrement remaining if N != 0.
- INACTIVE: hold H cycles; then if (N != 0 and remaining == 0) or stop flag set -> IDLE with `done_o`; else -> ACTIVE.
- `stop_i` in IDLE is ignored; `stop_i` during a burst never shortens the current half-period; burst ends after completing the current full cycle's idle half.
- `start_i` while `busy_o` = 1 is ignored; `start_i` and `stop_i` together in IDLE: start wins, stop is dropped.
- Phase counter saturates to reload at H; wrap of remaining counter cannot occur (decrement only when nonzero).
- Reset (any time, including mid-burst): state IDLE, `clk_o` = IDLE_HIGH, `busy_o`/`lead_o`/`trail_o`/`done_o` = 0, counters 0, stop flag 0. Mid-burst reset may truncate a pulse; accepted.

## Timing
- All outputs registered; no combinational input-to-output path.
- Start sampled at edge t -> at t+1: `clk_o` active, `lead_o` = 1, `busy_o` = 1.
- Active level spans H cycles; `clk_o` idle and `trail_o` = 1 at t+H+1; next `lead_o` at t+2H+1. Period exactly 2H, duty 50%.
- Burst of N ends at t+2HN+1: `busy_o` = 0, `done_o` = 1 (same cycle). A start sampled in that cycle produces `lead_o` one cycle later; minimum idle-level time before any new active edge is H+1 cycles.
- No level of `clk_o` ever lasts fewer than H cycles except across reset.

## Structure
- Package `sclk_gen_pkg`: one-hot state localparams (IDLE, ACTIVE, INACTIVE) and the H=0-to-1 clamp function.
- Sub-module `sclk_phase_counter`: loadable down-counter with terminal-count flag, parametrised by DIV_WIDTH; instantiated once.
- Formal block: state always one-hot; `lead_o`/`trail_o` never both high; each `clk_o` level held >= H cycles.

## Test plan
- H=4, N=3, IDLE_HIGH=1, start at cycle 10 -> `clk_o` low cycles 11-14, 19-22, 27-30; three `lead_o`, three `trail_o`; `done_o` and `busy_o` fall at cycle 35.
- H=0, N=2 -> behaves as H=1: `clk_o` toggles every cycle, 2 low pulses, `done_o` at start+5.
- N=0, H=3, `stop_i` pulsed mid-active-phase of cycle 5 -> phase completes, full idle half follows, `done_o` after 5th cycle's idle half; no short pulse.
- `start_i` held high continuously with N=1, H=2 -> back-to-back bursts, `done_o` and next start same cycle, `lead_o` next cycle, idle level >= 3 cycles between pulses.
- `rst_i` asserted asynchronously mid-active phase -> `clk_o` = idle level and `busy_o` = 0 before next `clk_i` edge; post-reset start behaves as from cold.
- IDLE_HIGH=0, H=5, N=1; `half_period_i` changed to 2 mid-burst -> period stays 10 cycles (latched value used).

Source files
------------

// File: rtl/sclk_gen_pkg.sv
// Shared definitions for the programmable burst serial clock generator:
// one-hot state encoding and the half-period clamp helper.
package sclk_gen_pkg;

    localparam logic [2:0] ONEHOT_IDLE     = 3'b001;
    localparam logic [2:0] ONEHOT_ACTIVE   = 3'b010;
    localparam logic [2:0] ONEHOT_INACTIVE = 3'b100;

    typedef enum logic [2:0] {
        IDLE     = ONEHOT_IDLE,
        ACTIVE   = ONEHOT_ACTIVE,
        INACTIVE = ONEHOT_INACTIVE
    } state_t;

    // A zero half-period would stall the phase counter, so it runs as one cycle.
    function automatic int unsigned clamp_half_period(input int unsigned h);
        return (h == 0) ? 32'd1 : h;
    endfunction

endpackage

// File: rtl/sclk_phase_counter.sv
// Loadable saturating down-counter that times one half-period of the
// generated clock; tc marks the last cycle of the half-period.
module sclk_phase_counter #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] load_value,
    output logic                 tc
);

    logic [DIV_WIDTH-1:0] count;

    // Holds at zero between loads, so tc stays asserted while idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/sclk_gen.sv
// Burst-capable serial clock generator: runtime half-period, fixed idle
// polarity, N-cycle or free-running bursts, and edge strobes in the clk_i domain.
module sclk_gen
    import sclk_gen_pkg::*;
#(
    parameter int DIV_WIDTH   = 8,
    parameter int COUNT_WIDTH = 8,
    parameter bit IDLE_HIGH   = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [DIV_WIDTH-1:0]   half_period_i,
    input  logic [COUNT_WIDTH-1:0] count_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    output logic                   clk_o,
    output logic                   busy_o,
    output logic                   lead_o,
    output logic                   trail_o,
    output logic                   done_o
);

    localparam logic IDLE_LEVEL = IDLE_HIGH;

    state_t                 state;
    state_t                 state_next;
    logic [DIV_WIDTH-1:0]   h_lat;
    logic [DIV_WIDTH-1:0]   h_clamped;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   free_run;
    logic                   stop_flag;
    logic                   end_burst;
    logic                   phase_load;
    logic [DIV_WIDTH-1:0]   phase_load_val;
    logic                   phase_tc;
    logic                   clk_next;
    logic                   busy_next;
    logic                   lead_next;
    logic                   trail_next;
    logic                   done_next;

    assign h_clamped = DIV_WIDTH'(clamp_half_period(32'(half_period_i)));

    sclk_phase_counter #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_phase (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load       (phase_load),
        .load_value (phase_load_val),
        .tc         (phase_tc)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A live stop_i counts too, so a stop landing on the final idle cycle still ends the burst.
    always_comb begin
        state_next     = state;
        clk_next       = clk_o;
        busy_next      = busy_o;
        lead_next      = 1'b0;
        trail_next     = 1'b0;
        done_next      = 1'b0;
        phase_load     = 1'b0;
        phase_load_val = h_lat - 1'b1;
        end_burst      = (!free_run && (remaining == '0)) || stop_flag || stop_i;
        case (state)
            IDLE: begin
                clk_next  = IDLE_LEVEL;
                busy_next = 1'b0;
                if (start_i) begin
                    state_next     = ACTIVE;
                    clk_next       = ~IDLE_LEVEL;
                    busy_next      = 1'b1;
                    lead_next      = 1'b1;
                    phase_load     = 1'b1;
                    phase_load_val = h_clamped - 1'b1;
                end
            end
            ACTIVE: begin
                if (phase_tc) begin
                    state_next = INACTIVE;
                    clk_next   = IDLE_LEVEL;
                    trail_next = 1'b1;
                    phase_load = 1'b1;
                end
            end
            INACTIVE: begin
                if (phase_tc) begin
                    if (end_burst) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ACTIVE;
                        clk_next   = ~IDLE_LEVEL;
                        lead_next  = 1'b1;
                        phase_load = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                clk_next   = IDLE_LEVEL;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_o     <= IDLE_LEVEL;
            busy_o    <= 1'b0;
            lead_o    <= 1'b0;
            trail_o   <= 1'b0;
            done_o    <= 1'b0;
            h_lat     <= '0;
            remaining <= '0;
            free_run  <= 1'b0;
            stop_flag <= 1'b0;
        end else begin
            clk_o   <= clk_next;
            busy_o  <= busy_next;
            lead_o  <= lead_next;
            trail_o <= trail_next;
            done_o  <= done_next;
            if (state == IDLE) begin
                stop_flag <= 1'b0;
                if (start_i) begin
                    h_lat     <= h_clamped;
                    remaining <= count_i;
                    free_run  <= (count_i == '0);
                end
            end else begin
                if (state_next == IDLE) begin
                    stop_flag <= 1'b0;
                end else if (stop_i) begin
                    stop_flag <= 1'b1;
                end
                if ((state == ACTIVE) && phase_tc && (remaining != '0)) begin
                    remaining <= remaining - 1'b1;
                end
            end
        end
    end

`ifndef SYNTHESIS
    logic [DIV_WIDTH:0] run_len;

    // Length of the current clk_o level, for the minimum-level-width check.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_len <= '0;
        end else if (clk_next != clk_o) begin
            run_len <= (DIV_WIDTH+1)'(1);
        end else if (run_len != '1) begin
            run_len <= run_len + 1'b1;
        end
    end

    a_state_onehot : assert property (@(posedge clk_i) disable iff (rst_i) $onehot(state));
    a_strobe_excl  : assert property (@(posedge clk_i) disable iff (rst_i) !(lead_o && trail_o));
    a_level_hold   : assert property (@(posedge clk_i) disable iff (rst_i)
                         (busy_o && (clk_next != clk_o)) |-> ({1'b0, h_lat} <= run_len));
`endif

endmodule
